// File: rtl/project_switch_sequencer.sv
// Wishbone-driven project switcher: isolates pads, holds projects in reset, swaps the IO mux select.
// Single-cycle bus ack (never back-to-back); a switch occupies RST_CYCLES+3 cycles from ISOLATE to IDLE.
module project_switch_sequencer #(
  parameter int          NUM_PROJECTS = 8,
  parameter int          IO_PADS      = 38,
  parameter int          RST_CYCLES   = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [7:0]              active_project_o,
  output logic [NUM_PROJECTS-1:0] project_rst_o,
  output logic [IO_PADS-1:0]      io_oeb,
  output logic                    busy_o
);
  localparam int HI_W = IO_PADS - 32;
  localparam int CW   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISOLATE, S_RESET, S_SWITCH, S_RELEASE} state_t;

  function automatic logic [NUM_PROJECTS-1:0] onehot(input logic [7:0] idx);
    return NUM_PROJECTS'(1) << idx;
  endfunction

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    ack_q, ack_d;
  logic [31:0]             dat_q, dat_d;
  logic [7:0]              active_q, active_d;
  logic [7:0]              target_q, target_d;
  logic [7:0]              pend_proj_q, pend_proj_d;
  logic                    pending_q, pending_d;
  logic                    err_q, err_d;
  logic [IO_PADS-1:0]      shadow_q, shadow_d;
  logic [IO_PADS-1:0]      oeb_q, oeb_d;
  logic [NUM_PROJECTS-1:0] prst_q, prst_d;

  logic        bus_req, wr, rd, busy, enter_iso;
  logic        hit_sel, hit_oeb0, hit_oeb1, hit_stat, sel_bad;
  logic [31:0] lane_m;

  assign bus_req  = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr       = bus_req & wbs_we_i;
  assign rd       = bus_req & ~wbs_we_i;
  assign hit_sel  = (wbs_adr_i == BASE_ADDR);
  assign hit_oeb0 = (wbs_adr_i == BASE_ADDR + 32'h4);
  assign hit_oeb1 = (wbs_adr_i == BASE_ADDR + 32'h8);
  assign hit_stat = (wbs_adr_i == BASE_ADDR + 32'hC);
  assign sel_bad  = {24'h0, wbs_dat_i[7:0]} >= 32'(NUM_PROJECTS);
  assign lane_m   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign busy     = (state_q != S_IDLE);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      active_q    <= '0;
      target_q    <= '0;
      pend_proj_q <= '0;
      pending_q   <= 1'b0;
      err_q       <= 1'b0;
      shadow_q    <= '1;
      oeb_q       <= '1;
      prst_q      <= ~NUM_PROJECTS'(1);
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      active_q    <= active_d;
      target_q    <= target_d;
      pend_proj_q <= pend_proj_d;
      pending_q   <= pending_d;
      err_q       <= err_d;
      shadow_q    <= shadow_d;
      oeb_q       <= oeb_d;
      prst_q      <= prst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE:    if (pending_q) state_d = S_ISOLATE;
      S_ISOLATE: state_d = S_RESET;
      S_RESET: begin
        if (cnt_q == CNT_LAST) state_d = S_SWITCH;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_SWITCH:  state_d = S_RELEASE;
      S_RELEASE: state_d = (pending_q && pend_proj_q != target_q) ? S_ISOLATE : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign enter_iso = (state_d == S_ISOLATE) && (state_q == S_IDLE || state_q == S_RELEASE);

  always_comb begin
    ack_d       = bus_req;
    dat_d       = '0;
    active_d    = active_q;
    target_d    = target_q;
    pend_proj_d = pend_proj_q;
    pending_d   = pending_q;
    err_d       = err_q;
    shadow_d    = shadow_q;
    oeb_d       = oeb_q;
    prst_d      = prst_q;

    case (state_q)
      S_IDLE:    oeb_d = shadow_q;
      S_SWITCH:  begin oeb_d = '1; active_d = target_q; end
      S_RELEASE: begin oeb_d = shadow_q; prst_d = ~onehot(target_q); end
      default:   oeb_d = '1;
    endcase

    // Back-to-back switches keep pads isolated and every involved project in reset.
    if (enter_iso) begin
      target_d  = pend_proj_q;
      pending_d = 1'b0;
      oeb_d     = '1;
      prst_d    = prst_q | onehot(active_q) | onehot(pend_proj_q);
    end
    if (state_q == S_RELEASE && pending_q && pend_proj_q == target_q) pending_d = 1'b0;

    // Bus writes follow the FSM so a selection landing on the entry edge is not lost.
    if (wr) begin
      if (hit_sel && wbs_sel_i[0]) begin
        if (sel_bad) begin
          err_d = 1'b1;
        end else if (!(state_q == S_IDLE && wbs_dat_i[7:0] == active_q)) begin
          pend_proj_d = wbs_dat_i[7:0];
          pending_d   = 1'b1;
        end
      end
      if (hit_oeb0)
        shadow_d[31:0] = (shadow_q[31:0] & ~lane_m) | (wbs_dat_i & lane_m);
      if (hit_oeb1)
        shadow_d[IO_PADS-1:32] = (shadow_q[IO_PADS-1:32] & ~lane_m[HI_W-1:0]) |
                                 (wbs_dat_i[HI_W-1:0] & lane_m[HI_W-1:0]);
      if (hit_stat && wbs_sel_i[0] && wbs_dat_i[2]) err_d = 1'b0;
    end

    if (rd) begin
      if (hit_sel)  dat_d = {24'h0, active_q};
      if (hit_oeb0) dat_d = shadow_q[31:0];
      if (hit_oeb1) dat_d = 32'(shadow_q[IO_PADS-1:32]);
      if (hit_stat) dat_d = {8'h0, active_q, pend_proj_q, 5'h0, err_q, pending_q, busy};
    end
  end

  assign wbs_ack_o        = ack_q;
  assign wbs_dat_o        = dat_q;
  assign active_project_o = active_q;
  assign project_rst_o    = prst_q;
  assign io_oeb           = oeb_q;
  assign busy_o           = busy;
endmodule

// File: tb/tb_project_switch_sequencer.sv
// Directed bench for project_switch_sequencer; bus responses checked through a scoreboard queue.
module tb_project_switch_sequencer;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_SEL = BASE, A_OEB0 = BASE + 32'h4, A_OEB1 = BASE + 32'h8, A_STAT = BASE + 32'hC;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack, busy;
  logic [31:0] dat_o;
  logic [7:0]  active, rst_o;
  logic [37:0] io_oeb;

  logic [31:0] exp_q[$];
  int          n_vec = 0, n_err = 0;
  logic        prev_ack = 1'b0;
  logic [7:0]  prev_active = 8'h0;

  project_switch_sequencer #(
    .NUM_PROJECTS(8), .IO_PADS(38), .RST_CYCLES(16), .BASE_ADDR(BASE)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .active_project_o(active), .project_rst_o(rst_o), .io_oeb(io_oeb), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every ack consumes one expected read-data word.
  always @(negedge clk) begin
    if (ack) begin
      chk("ack_gap", 64'(prev_ack), 64'd0);
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sb_empty: ack with no expected response, dat_o %0h", dat_o);
      end else begin
        chk("sb_dat", 64'(dat_o), 64'(exp_q.pop_front()));
      end
    end
    if (active != prev_active) chk("glitch_oeb", 64'(io_oeb == {38{1'b1}}), 64'd1);
    prev_ack    = ack;
    prev_active = active;
  end

  // Called at a negedge; returns at the negedge where ack is seen.
  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [31:0] exp);
    int n;
    exp_q.push_back(exp);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack && n < 8);
    if (!ack) begin n_vec++; n_err++; $display("FAIL wb_timeout: no ack at adr %0h", a); end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic watch(input logic [7:0] tgt, input logic [7:0] mask, output int nbusy,
                       output int sw_idx, output bit oeb_ok, output bit rst_ok);
    int w;
    nbusy = 0; sw_idx = -1; oeb_ok = 1'b1; rst_ok = 1'b1; w = 0;
    while (!busy && w < 10) begin @(negedge clk); w++; end
    while (busy && nbusy < 100) begin
      if (io_oeb !== {38{1'b1}}) oeb_ok = 1'b0;
      if ((rst_o & mask) !== mask) rst_ok = 1'b0;
      if (sw_idx < 0 && active === tgt) sw_idx = nbusy;
      nbusy++;
      @(negedge clk);
    end
  endtask

  initial begin
    int  nb, sw, acks;
    bit  ook, rok;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_active", 64'(active), 64'h0);
    chk("rst_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    chk("rst_prst", 64'(rst_o), 64'hFE);
    chk("rst_ack", 64'(ack), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    wb(1'b0, A_STAT, 32'h0, 4'hF, 32'h0);

    // Switch 0 -> 3, enable low 32 pads while the sequence runs
    fork
      begin
        wb(1'b1, A_SEL, 32'h3, 4'h1, 32'h0);
        wb(1'b1, A_OEB0, 32'h0, 4'hF, 32'h0);
      end
      watch(8'd3, 8'h09, nb, sw, ook, rok);
    join
    chk("t2_busy_cycles", 64'(nb), 64'd19);
    chk("t2_switch_idx", 64'(sw), 64'd18);
    chk("t2_oeb_isolated", 64'(ook), 64'd1);
    chk("t2_rst_held", 64'(rok), 64'd1);
    chk("t2_active", 64'(active), 64'h3);
    chk("t2_oeb_final", 64'(io_oeb), 64'h3F_0000_0000);
    chk("t2_prst_final", 64'(rst_o), 64'hF7);

    // Out-of-range selection, error clear, reselecting the active project
    wb(1'b1, A_SEL, 32'h9, 4'h1, 32'h0);
    @(negedge clk);
    chk("t3_active", 64'(active), 64'h3);
    chk("t3_busy", 64'(busy), 64'h0);
    wb(1'b0, A_STAT, 32'h0, 4'hF, 32'h0003_0304);
    wb(1'b1, A_STAT, 32'h4, 4'h1, 32'h0);
    wb(1'b0, A_STAT, 32'h0, 4'hF, 32'h0003_0300);
    wb(1'b1, A_SEL, 32'h3, 4'h1, 32'h0);
    repeat (2) @(negedge clk);
    chk("t3_same_no_busy", 64'(busy), 64'h0);
    wb(1'b0, A_SEL, 32'h0, 4'hF, 32'h3);

    // Chained switch 3 -> 2 -> 5 with byte-lane OEB writes while busy
    fork
      begin
        wb(1'b1, A_SEL, 32'h2, 4'h1, 32'h0);
        repeat (3) @(negedge clk);
        wb(1'b1, A_SEL, 32'h5, 4'h1, 32'h0);
        wb(1'b1, A_OEB1, 32'hFFFF_FFC0, 4'h1, 32'h0);
        wb(1'b1, A_OEB0, 32'hFFFF_FFFF, 4'h4, 32'h0);
        wb(1'b0, A_OEB1, 32'h0, 4'hF, 32'h0);
        wb(1'b0, A_OEB0, 32'h0, 4'hF, 32'h00FF_0000);
      end
      watch(8'd5, 8'h2C, nb, sw, ook, rok);
    join
    chk("t4_busy_cycles", 64'(nb), 64'd38);
    chk("t4_switch_idx", 64'(sw), 64'd37);
    chk("t4_oeb_isolated", 64'(ook), 64'd1);
    chk("t4_rst_held", 64'(rok), 64'd1);
    chk("t4_active", 64'(active), 64'h5);
    chk("t4_prst_final", 64'(rst_o), 64'hDF);
    chk("t5_oeb_final", 64'(io_oeb), 64'h00_00FF_0000);
    wb(1'b0, A_STAT, 32'h0, 4'hF, 32'h0005_0500);

    // Asynchronous reset in the middle of a sequence
    wb(1'b1, A_SEL, 32'h1, 4'h1, 32'h0);
    repeat (4) @(negedge clk);
    chk("ar_busy_before", 64'(busy), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("ar_active", 64'(active), 64'h0);
    chk("ar_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    chk("ar_prst", 64'(rst_o), 64'hFE);
    chk("ar_busy", 64'(busy), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("ar_pending_lost", 64'(busy), 64'h0);
    wb(1'b0, A_STAT, 32'h0, 4'hF, 32'h0);

    // Unmapped address with cyc/stb held: ack alternates, data reads zero
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h20; sel = 4'hF;
    acks = 0;
    repeat (4) begin @(negedge clk); if (ack) acks++; end
    cyc = 1'b0; stb = 1'b0;
    chk("t6_ack_count", 64'(acks), 64'd2);

    repeat (3) @(negedge clk);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
